serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around one `full_adder` instance, which supplies its combinational sum and carry.
- Sequential wrapper: operand shift registers, a carry flip-flop, a bit counter and a small FSM.
- Adds one bit per clock, LSB first.
- Trades latency for area. Sits between operand registers and any consumer that accepts a Done-qualified result.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  reset, synchronous, active-high
- Start  input  1  request; sampled only in IDLE or DONE
- A  input  WIDTH  operand A; captured on the accepting edge
- B  input  WIDTH  operand B; captured on the accepting edge
- Cin  input  1  carry-in; captured on the accepting edge
- S  output  WIDTH  registered sum; valid while Done=1 and held until the next completion
- Cout  output  1  registered carry-out; same validity as S
- Busy  output  1  high while an addition is in progress (state ADD)
- Done  output  1  one-cycle completion strobe (state DONE)

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high on Rst.
- Reset (Rst=1 at an edge) takes priority over everything:
  - state <= IDLE
  - S, Cout, Busy, Done <= 0
  - shift registers, carry flop and counter <= 0
- Reset mid-operation aborts the addition. No Done is produced, and S/Cout read 0 afterwards.
- States: IDLE, ADD, DONE. Busy and Done are Moore outputs: Busy=(state==ADD), Done=(state==DONE).
- IDLE:
  - Start=1 at an edge: load A into regA and B into regB, carry <= Cin, count <= 0, go to ADD.
  - Otherwise stay in IDLE.
- ADD, each edge:
  - `full_adder` inputs: regA[0], regB[0], carry.
  - regA and regB shift right by one, MSB filled with 0.
  - The sum bit shifts into the MSB of an internal sum register, which shifts right.
  - carry <= full_adder Cout; count <= count+1.
  - On the edge where count == WIDTH-1 (the WIDTH-th bit edge):
    - S <= completed sum register, including the bit produced on that edge
    - Cout <= carry produced on that edge
    - state -> DONE
- ADD ignores Start. Inputs A, B and Cin may change freely during ADD without effect.
- DONE lasts exactly one cycle:
  - Start=1: load new operands exactly as from IDLE, go to ADD. This gives back-to-back operation.
  - Otherwise go to IDLE.
- Latency:
  - Start accepted at edge k.
  - Bits processed at edges k+1 .. k+WIDTH.
  - Done=1 and S/Cout valid from edge k+WIDTH until edge k+WIDTH+1.
  - Throughput is one addition per WIDTH+1 cycles.
- S/Cout hold their last completed value through IDLE and the next ADD. They are updated only at completion or reset.
- Arithmetic: {Cout,S} = A + B + Cin, modulo 2^(WIDTH+1). No overflow flag.
- Counter width: clog2(WIDTH)+1 bits. It must not wrap before WIDTH-1 is reached.
- No combinational path from any input to any output.

Test Plan (WIDTH=8):
- Rst=1 for 2 edges, then release, then idle 3 cycles -> S=8'h00, Cout=0, Busy=0, Done=0 throughout.
- A=8'h3C, B=8'h05, Cin=0, Start pulsed at edge k -> Busy=1 for edges k+1..k+8, Done=1 exactly one cycle after edge k+8, S=8'h41, Cout=0; S still 8'h41 five cycles later.
- A=8'hFF, B=8'h01, Cin=0 -> S=8'h00, Cout=1. Then A=8'hFF, B=8'hFF, Cin=1 -> S=8'hFF, Cout=1 (full carry ripple across all bits).
- Start held high continuously with A=8'h10, B=8'h20, then A/B changed to 8'hAA/8'h55 mid-ADD -> first result S=8'h30; second addition starts from DONE with no IDLE cycle and yields S=8'hFF, Cout=0. Done pulses spaced exactly 9 cycles apart.
- Start with A=8'h7F, B=8'h01; assert Rst at the 4th ADD edge -> next cycle: state IDLE, Busy=0, S=8'h00, Cout=0, and no Done pulse appears.
- Randomised 500 operands with random Cin and random Start gaps vs reference model A+B+Cin -> all {Cout,S} match, and Done never asserts without a prior accepted Start.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder processes one bit per clock, LSB first.
// The result {Cout,S} is registered at completion and qualified by a one-cycle Done strobe.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Busy,
   output logic             Done
);
   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic             load;
   logic             last;
   logic [WIDTH-1:0] reg_a;
   logic [WIDTH-1:0] reg_b;
   logic [WIDTH-1:0] sum_reg;
   logic [WIDTH-1:0] sum_next;
   logic             carry;
   logic [CW-1:0]    count;
   logic             fa_sum;
   logic             fa_cout;

   full_adder u_fa (
      .a    (reg_a[0]),
      .b    (reg_b[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign sum_next = {fa_sum, sum_reg[WIDTH-1:1]};

   // State register
   always_ff @(posedge Clk) begin
      if (Rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   // Next-state and control decode
   always_comb begin
      next_state = state;
      load       = 1'b0;
      last       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (Start) begin
               load       = 1'b1;
               next_state = ST_ADD;
            end
         end
         ST_ADD: begin
            if (count == CW'(WIDTH - 1)) begin
               last       = 1'b1;
               next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            if (Start) begin
               load       = 1'b1;
               next_state = ST_ADD;
            end else begin
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Datapath, result and status registers
   always_ff @(posedge Clk) begin
      if (Rst) begin
         reg_a   <= '0;
         reg_b   <= '0;
         sum_reg <= '0;
         carry   <= 1'b0;
         count   <= '0;
         S       <= '0;
         Cout    <= 1'b0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
      end else begin
         Busy <= (next_state == ST_ADD);
         Done <= (next_state == ST_DONE);
         if (load) begin
            reg_a <= A;
            reg_b <= B;
            carry <= Cin;
            count <= '0;
         end else if (state == ST_ADD) begin
            reg_a   <= {1'b0, reg_a[WIDTH-1:1]};
            reg_b   <= {1'b0, reg_b[WIDTH-1:1]};
            sum_reg <= sum_next;
            carry   <= fa_cout;
            count   <= count + CW'(1);
         end
         // Final bit edge: publish the completed sum including this edge's bit
         if (last) begin
            S    <= sum_next;
            Cout <= fa_cout;
         end
      end
   end
endmodule
